// File: rtl/lcd1602_pkg.sv
// Shared types and HD44780 command constants for the LCD1602 refresh driver.
package lcd1602_pkg;

    typedef enum logic [2:0] {
        POWERUP,
        INIT,
        L1_ADDR,
        L1_DATA,
        L2_ADDR,
        L2_DATA
    } state_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment address, no shift
    localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (long execution)
    localparam logic [7:0] CMD_L1_ADDR  = 8'h80;  // DDRAM address of line 1, column 0
    localparam logic [7:0] CMD_L2_ADDR  = 8'hC0;  // DDRAM address of line 2, column 0

    // Command byte for each of the four init steps, in issue order.
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd1602_slot_timer.sv
// Bus slot sequencer: counts c = 0..slot_len-1 after each start pulse,
// drives the enable strobe for c in 1..EN_CYCLES and flags the slot's last cycle.
module lcd1602_slot_timer #(
    parameter int unsigned EN_CYCLES = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] slot_len,
    output logic [31:0] slot_cnt,
    output logic        active,
    output logic        lcd_en,
    output logic        slot_end
);

    logic        active_q, active_d;
    logic [31:0] cnt_q, cnt_d;

    assign slot_end = active_q && (cnt_q == slot_len - 32'd1);
    assign lcd_en   = active_q && (cnt_q >= 32'd1) && (cnt_q <= EN_CYCLES);
    assign slot_cnt = cnt_q;
    assign active   = active_q;

    // Next counter value: a start (re)opens a slot at c=0, otherwise count up and stop at the end.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        active_d = active_q;
        cnt_d    = cnt_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = 32'd0;
        end else if (active_q) begin
            if (slot_end) begin
                active_d = 1'b0;
                cnt_d    = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd1602_driver.sv
// LCD1602 (HD44780, 8-bit bus) write-only driver: power-up wait, init sequence,
// then endless 34-slot refresh of 32 characters from a per-frame snapshot.
module lcd1602_driver
    import lcd1602_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned WR_CYCLES      = 2500,
    parameter int unsigned CLR_CYCLES     = 100000,
    parameter int unsigned EN_CYCLES      = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] dis_data,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         frame_done
);

    state_e       state_q, state_d;
    logic [4:0]   idx_q, idx_d;        // init step in INIT, character index in the data states
    logic [31:0]  pwr_q, pwr_d;
    logic [255:0] snap_q, snap_d;
    logic         init_done_q, init_done_d;

    logic         start;
    logic [31:0]  slot_len;
    logic [31:0]  slot_cnt;
    logic         slot_active;
    logic         slot_end;

    // Only the clear command needs the long slot.
    assign slot_len = (state_q == INIT && idx_q == 5'd3) ? CLR_CYCLES : WR_CYCLES;

    lcd1602_slot_timer #(
        .EN_CYCLES (EN_CYCLES)
    ) u_slot_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .slot_len (slot_len),
        .slot_cnt (slot_cnt),
        .active   (slot_active),
        .lcd_en   (lcd_en),
        .slot_end (slot_end)
    );

    // State and counter registers.
    always_ff @(posedge clk) begin
        // NOTE: the snapshot is an ordinary 256-bit register, not a RAM, so it is cleared on reset like any other flop.
        if (rst) begin
            state_q     <= POWERUP;
            idx_q       <= 5'd0;
            pwr_q       <= 32'd0;
            snap_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pwr_q       <= pwr_d;
            snap_q      <= snap_d;
            init_done_q <= init_done_d;
        end
    end

    // Next state: every slot end immediately starts the following slot, so frames have no gaps.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pwr_d       = pwr_q;
        init_done_d = init_done_q;
        start       = 1'b0;
        snap_d      = (state_q == L1_ADDR && slot_active && slot_cnt == 32'd0) ? dis_data : snap_q;
        case (state_q)
            POWERUP: begin
                if (pwr_q == POWERUP_CYCLES - 32'd1) begin
                    start   = 1'b1;
                    state_d = INIT;
                    idx_d   = 5'd0;
                    pwr_d   = 32'd0;
                end else begin
                    pwr_d = pwr_q + 32'd1;
                end
            end
            INIT: begin
                if (slot_end) begin
                    start = 1'b1;
                    if (idx_q == 5'd3) begin
                        state_d     = L1_ADDR;
                        idx_d       = 5'd0;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            L1_ADDR: begin
                if (slot_end) begin
                    start   = 1'b1;
                    state_d = L1_DATA;
                end
            end
            L1_DATA: begin
                if (slot_end) begin
                    start = 1'b1;
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd15) state_d = L2_ADDR;
                end
            end
            L2_ADDR: begin
                if (slot_end) begin
                    start   = 1'b1;
                    state_d = L2_DATA;
                end
            end
            L2_DATA: begin
                if (slot_end) begin
                    start = 1'b1;
                    idx_d = idx_q + 5'd1;  // wraps 31 -> 0 at the frame boundary
                    if (idx_q == 5'd31) state_d = L1_ADDR;
                end
            end
            default: state_d = POWERUP;
        endcase
    end

    // Bus outputs: rs/data are held for the whole slot; the strobe comes from the slot timer.
    always_comb begin
        lcd_rs   = 1'b0;
        lcd_data = 8'h00;
        case (state_q)
            INIT:    lcd_data = init_cmd(idx_q[1:0]);
            L1_ADDR: lcd_data = CMD_L1_ADDR;
            L2_ADDR: lcd_data = CMD_L2_ADDR;
            L1_DATA, L2_DATA: begin
                lcd_rs   = 1'b1;
                lcd_data = snap_q[{idx_q, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    assign lcd_rw     = 1'b0;
    assign init_done  = init_done_q;
    assign frame_done = (state_q == L2_DATA) && (idx_q == 5'd31) && slot_end;

endmodule

// File: tb/tb_lcd1602_driver.sv
// Self-checking bench for lcd1602_driver with short simulation timings.
module tb_lcd1602_driver;

    localparam int unsigned P_PWR = 20;
    localparam int unsigned P_WR  = 8;
    localparam int unsigned P_CLR = 16;
    localparam int unsigned P_EN  = 2;
    localparam int FRAME = 34 * P_WR;   // 272 cycles
    localparam int FIRST_EN = 21;        // 20 idle cycles, slot c=0, then strobe
    localparam int INIT_DONE_AT = 20 + 8 + 8 + 8 + 16;
    localparam int FRAME0_EN = INIT_DONE_AT + 1;

    typedef struct packed {
        logic       en;
        logic       rs;
        logic       rw;
        logic [7:0] data;
        logic       init_done;
        logic       frame_done;
    } sample_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] dis_data;
    logic         lcd_rs, lcd_rw, lcd_en;
    logic [7:0]   lcd_data;
    logic         init_done, frame_done;

    int checks = 0;
    int errors = 0;

    sample_t    hist[$];   // one sample per cycle since the last reset release
    logic [8:0] exp_q[$];  // expected {rs, data} for each enable strobe, in order
    int         scan_pos = 0;

    string      line1_a = " smart pill box ";
    string      line2_a = "    12:34:56    ";
    logic [7:0] b_bytes[32];
    logic [255:0] frame_a, frame_b;

    lcd1602_driver #(
        .POWERUP_CYCLES (P_PWR),
        .WR_CYCLES      (P_WR),
        .CLR_CYCLES     (P_CLR),
        .EN_CYCLES      (P_EN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dis_data   (dis_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Record the bus away from the active edge.
    always @(negedge clk) begin
        hist.push_back({lcd_en, lcd_rs, lcd_rw, lcd_data, init_done, frame_done});
    end

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        hist.delete();
        scan_pos = 0;
    endtask

    task automatic wait_samples(input int n);
        while (hist.size() < n) @(negedge clk);
    endtask

    // Next enable rising edge in the recorded history, or at = -1 if none.
    task automatic next_rise(output logic [8:0] b, output int at);
        at = -1;
        b  = '0;
        for (int i = scan_pos; i < hist.size(); i++) begin
            if (hist[i].en && (i == 0 || !hist[i-1].en)) begin
                at = i;
                b = {hist[i].rs, hist[i].data};
                scan_pos = i + 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", lcd_en); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b expected 0", lcd_rw); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", lcd_data); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    endtask

    task automatic test_powerup_init();
        logic [8:0] b, e;
        int at, n, first_en, first_init;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
        release_reset();
        n = 0;
        while (!init_done && n < 200) begin @(negedge clk); n++; end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_timeout: got %b expected 1 within 200 cycles", init_done); end
        wait_samples(INIT_DONE_AT + 2);
        first_en = -1;
        first_init = -1;
        for (int i = 0; i < hist.size(); i++) begin
            if (first_en < 0 && hist[i].en) first_en = i;
            if (first_init < 0 && hist[i].init_done) first_init = i;
        end
        checks++; if (first_en != FIRST_EN) begin errors++; $display("FAIL powerup_first_en: got cycle %0d expected %0d", first_en, FIRST_EN); end
        checks++; if (first_init != INIT_DONE_AT) begin errors++; $display("FAIL init_done_rise: got cycle %0d expected %0d", first_init, INIT_DONE_AT); end
        for (int s = 0; s < 4; s++) begin
            next_rise(b, at);
            e = exp_q.pop_front();
            checks++; if (at < 0 || b !== e) begin errors++; $display("FAIL init_cmd%0d: got %h expected %h", s, b, e); end
            checks++; if (at != FIRST_EN + 8 * s) begin errors++; $display("FAIL init_slot%0d_time: got %0d expected %0d", s, at, FIRST_EN + 8 * s); end
        end
    endtask

    task automatic test_content();
        logic [8:0] b, e;
        int at, fd_first, fd_count;
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, line1_a[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, line2_a[i]});
        // Change the input while character 5 of frame 0 is on the bus.
        wait_samples(FRAME0_EN + 8 * 6 + 2);
        dis_data = frame_b;
        wait_samples(FRAME0_EN + FRAME + 4);
        for (int j = 0; j < 34; j++) begin
            next_rise(b, at);
            e = exp_q.pop_front();
            checks++; if (at < 0 || b !== e) begin errors++; $display("FAIL frame0_slot%0d: got %h expected %h", j, b, e); end
            checks++; if (at != FRAME0_EN + 8 * j) begin errors++; $display("FAIL frame0_slot%0d_time: got %0d expected %0d", j, at, FRAME0_EN + 8 * j); end
        end
        fd_first = -1;
        fd_count = 0;
        for (int i = 0; i < FRAME0_EN + FRAME; i++) begin
            if (hist[i].frame_done) begin
                fd_count++;
                if (fd_first < 0) fd_first = i;
            end
        end
        checks++; if (fd_first != INIT_DONE_AT + FRAME - 1) begin errors++; $display("FAIL frame_done_first: got %0d expected %0d", fd_first, INIT_DONE_AT + FRAME - 1); end
        checks++; if (fd_count != 1) begin errors++; $display("FAIL frame_done_width: got %0d expected 1", fd_count); end
    endtask

    task automatic test_snapshot();
        logic [8:0] b, e;
        int at, fd_count, fd_last;
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, b_bytes[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, b_bytes[i]});
        wait_samples(FRAME0_EN + 2 * FRAME + 10);
        for (int j = 0; j < 34; j++) begin
            next_rise(b, at);
            e = exp_q.pop_front();
            checks++; if (at < 0 || b !== e) begin errors++; $display("FAIL frame1_slot%0d: got %h expected %h", j, b, e); end
            checks++; if (at != FRAME0_EN + FRAME + 8 * j) begin errors++; $display("FAIL frame1_slot%0d_time: got %0d expected %0d", j, at, FRAME0_EN + FRAME + 8 * j); end
        end
        fd_count = 0;
        fd_last = -1;
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].frame_done) begin fd_count++; fd_last = i; end
        end
        checks++; if (fd_count != 2) begin errors++; $display("FAIL frame_done_count: got %0d expected 2", fd_count); end
        checks++; if (fd_last != INIT_DONE_AT + 2 * FRAME - 1) begin errors++; $display("FAIL frame_done_period: got %0d expected %0d", fd_last, INIT_DONE_AT + 2 * FRAME - 1); end
    endtask

    task automatic test_timing();
        int pulses, width, bad_stable, init_drop, rw_bad;
        pulses = 0;
        for (int r = 1; r + 6 < hist.size(); r++) begin
            if (hist[r].en && !hist[r-1].en) begin
                pulses++;
                width = 0;
                while (hist[r + width].en && width < 6) width++;
                checks++; if (width != P_EN) begin errors++; $display("FAIL en_width_at%0d: got %0d expected %0d", r, width, P_EN); end
                bad_stable = 0;
                for (int k = r - 1; k <= r + 6; k++)
                    if ({hist[k].rs, hist[k].data} !== {hist[r].rs, hist[r].data}) bad_stable++;
                checks++; if (bad_stable != 0) begin errors++; $display("FAIL data_stable_at%0d: got %0d changed cycles expected 0", r, bad_stable); end
            end
        end
        checks++; if (pulses != 73) begin errors++; $display("FAIL pulse_count: got %0d expected 73", pulses); end
        init_drop = 0;
        rw_bad = 0;
        for (int i = 0; i < hist.size(); i++) begin
            if (i >= INIT_DONE_AT && hist[i].init_done !== 1'b1) init_drop++;
            if (hist[i].rw !== 1'b0) rw_bad++;
        end
        checks++; if (init_drop != 0) begin errors++; $display("FAIL init_done_sticky: got %0d low cycles expected 0", init_drop); end
        checks++; if (rw_bad != 0) begin errors++; $display("FAIL rw_constant: got %0d nonzero cycles expected 0", rw_bad); end
    endtask

    task automatic test_reset_mid_pulse();
        logic [8:0] b, e;
        int at, n, first_en;
        n = 0;
        @(negedge clk);
        while (!lcd_en && n < 50) begin @(negedge clk); n++; end
        checks++; if (lcd_en !== 1'b1) begin errors++; $display("FAIL mid_pulse_timeout: got %b expected 1 within 50 cycles", lcd_en); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL mid_reset_en: got %b expected 0", lcd_en); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h expected 00", lcd_data); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_reset_init_done: got %b expected 0", init_done); end
        repeat (2) @(posedge clk);
        exp_q.push_back({1'b0, 8'h38});
        release_reset();
        wait_samples(FIRST_EN + 4);
        first_en = -1;
        for (int i = 0; i < hist.size(); i++)
            if (first_en < 0 && hist[i].en) first_en = i;
        checks++; if (first_en != FIRST_EN) begin errors++; $display("FAIL rerun_first_en: got cycle %0d expected %0d", first_en, FIRST_EN); end
        next_rise(b, at);
        e = exp_q.pop_front();
        checks++; if (at < 0 || b !== e) begin errors++; $display("FAIL rerun_cmd0: got %h expected %h", b, e); end
        checks++; if (hist[0].init_done !== 1'b0) begin errors++; $display("FAIL rerun_init_done: got %b expected 0", hist[0].init_done); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            frame_a[8*i +: 8]        = line1_a[i];
            frame_a[8*(i+16) +: 8]   = line2_a[i];
        end
        for (int i = 0; i < 32; i++) b_bytes[i] = 8'($urandom_range(0, 255));
        b_bytes[0]  = 8'hFF;
        b_bytes[5]  = 8'h00;
        b_bytes[31] = 8'h7E;
        for (int i = 0; i < 32; i++) frame_b[8*i +: 8] = b_bytes[i];
        dis_data = frame_a;

        test_reset();
        test_powerup_init();
        test_content();
        test_snapshot();
        test_timing();
        test_reset_mid_pulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
